// File: rtl/gouram_trace_if.sv
// Trace record input and 32-bit beat output stream of the Gouram trace reader.
interface gouram_trace_if #(
  parameter int unsigned TRACE_WIDTH = 128
);
  logic                   trace_valid_i;
  logic [TRACE_WIDTH-1:0] trace_data_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [31:0]            out_data_o;
  logic                   out_last_o;

  // Tracer/host side: drives records and beat ready, observes the beat stream.
  modport master (
    output trace_valid_i, trace_data_i, out_ready_i,
    input  out_valid_o, out_data_o, out_last_o
  );

  // Reader side.
  modport slave (
    input  trace_valid_i, trace_data_i, out_ready_i,
    output out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/gouram_trace_reader.sv
// Gouram trace reader: buffers trace records in a FIFO, serialises them into
// 32-bit beats, counts records lost to back-pressure and stops the run once
// the record carrying the stop instruction has been fully drained.
module gouram_trace_reader #(
  parameter int unsigned TRACE_WIDTH = 128,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  gouram_trace_if.slave          bus,
  input  logic                   stop_en_i,
  input  logic [31:0]            stop_instr_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [CNT_WIDTH-1:0]   drop_count_o,
  output logic                   done_o
);

  localparam int unsigned WORDS = (TRACE_WIDTH + 31) / 32;
  localparam int unsigned PAD_W = WORDS * 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             r_state, w_state_nxt;
  logic [TRACE_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]       r_tag;
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [LVL_W-1:0]       r_level, w_level_pop, w_level_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic                   r_stopped;
  logic                   r_out_valid, r_out_last;
  logic [31:0]            r_out_data;
  logic                   r_overflow, r_done;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  logic                   w_hs, w_last_hs, w_accept, w_drop, w_stop_hit;
  logic [TRACE_WIDTH-1:0] w_head;
  logic [PAD_W-1:0]       w_head_pad;
  logic [31:0]            w_beat;
  logic                   w_valid_nxt, w_last_nxt;

  // Handshake, accept/drop decision and FIFO occupancy arithmetic.
  assign w_hs         = r_out_valid & bus.out_ready_i;
  assign w_last_hs    = w_hs & r_out_last;
  assign w_accept     = bus.trace_valid_i & ~r_stopped &
                        ((r_level < LVL_W'(DEPTH)) | w_last_hs);
  assign w_drop       = bus.trace_valid_i & ~r_stopped & ~w_accept;
  assign w_stop_hit   = stop_en_i & (bus.trace_data_i[31:0] == stop_instr_i);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_last_hs);
  assign w_level_pop  = r_level - LVL_W'(w_last_hs);
  assign w_level_nxt  = w_level_pop + LVL_W'(w_accept);

  // Next head record; bypasses the incoming record when the FIFO drains to empty.
  assign w_head     = (w_level_pop == '0) ? bus.trace_data_i : r_mem[w_rd_ptr_nxt];
  assign w_head_pad = PAD_W'(w_head);
  assign w_beat     = w_head_pad[{w_idx_nxt, 5'b0} +: 32];

  // Output-side next state and beat index.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_level_nxt != '0) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_last_hs) begin
          w_idx_nxt = '0;
          if (r_tag[r_rd_ptr])         w_state_nxt = S_DONE;
          else if (w_level_nxt == '0)  w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_valid_nxt = (w_state_nxt == S_SEND);
  assign w_last_nxt  = w_valid_nxt & (w_idx_nxt == IDX_W'(WORDS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Record storage with per-entry stop tag; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= bus.trace_data_i;
      r_tag[r_wr_ptr] <= w_stop_hit;
    end
  end

  // Pointers, occupancy, stop flag, drop statistics and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_stopped   <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      if (w_accept & w_stop_hit) r_stopped <= 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_valid_nxt ? w_beat : 32'h0;
      r_out_last  <= w_last_nxt;
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_last_o  = r_out_last;
  assign level_o         = r_level;
  assign overflow_o      = r_overflow;
  assign drop_count_o    = r_drop_cnt;
  assign done_o          = r_done;

endmodule

// File: tb/tb_gouram_trace_reader.sv
// Scoreboard bench for gouram_trace_reader: stimulus pushes expected beats,
// a negedge monitor pops and compares every handshaken beat.
module tb_gouram_trace_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop_en;
  logic [31:0] stop_instr;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];

  gouram_trace_if #(.TRACE_WIDTH(128)) bus ();

  gouram_trace_reader #(.TRACE_WIDTH(128), .DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stop_en_i    (stop_en),
    .stop_instr_i (stop_instr),
    .level_o      (level),
    .overflow_o   (overflow),
    .drop_count_o (drop_count),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_record(input logic [127:0] rec);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), rec[32*k +: 32]});
  endtask

  task automatic strobe(input logic [127:0] rec);
    bus.trace_valid_i = 1'b1;
    bus.trace_data_i  = rec;
    step();
    bus.trace_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((level != 4'd0 || bus.out_valid_o) && i < 200) begin
      step();
      i++;
    end
    check(name, level, 4'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid_o, 1'b0);
    check({tag, "_data"},  bus.out_data_o, 32'h0);
    check({tag, "_last"},  bus.out_last_o, 1'b0);
    check({tag, "_level"}, level, 4'd0);
    check({tag, "_ovf"},   overflow, 1'b0);
    check({tag, "_drop"},  drop_count, 16'd0);
    check({tag, "_done"},  done, 1'b0);
  endtask

  function automatic logic [127:0] mk(input int i);
    mk = {32'hD000_0000 + 32'(i), 32'hC000_0000 + 32'(i),
          32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
  endfunction

  // Beat monitor: every handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got %0h last %0b expected no beat",
                 bus.out_data_o, bus.out_last_o);
      end else begin
        check("beat", {bus.out_last_o, bus.out_data_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [127:0] rec;
    int i;

    rst = 1'b1;
    stop_en = 1'b0;
    stop_instr = 32'h07002E03;
    bus.trace_valid_i = 1'b0;
    bus.trace_data_i  = '0;
    bus.out_ready_i   = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    // Single record, full throughput, hand-computed beats.
    bus.out_ready_i = 1'b1;
    exp_q.push_back({1'b0, 32'h4455_6677});
    exp_q.push_back({1'b0, 32'h0011_2233});
    exp_q.push_back({1'b0, 32'h89AB_CDEF});
    exp_q.push_back({1'b1, 32'h0123_4567});
    strobe(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    check("lat_valid", bus.out_valid_o, 1'b1);
    check("lat_data",  bus.out_data_o, 32'h4455_6677);
    check("lat_level", level, 4'd1);
    step(); step(); step(); step();
    check("single_level", level, 4'd0);
    check("single_idle",  bus.out_valid_o, 1'b0);

    // Back-pressure on beat 0 for five cycles.
    bus.out_ready_i = 1'b0;
    exp_q.push_back({1'b0, 32'h4B5A_6978});
    exp_q.push_back({1'b0, 32'h0F1E_2D3C});
    exp_q.push_back({1'b0, 32'h7654_3210});
    exp_q.push_back({1'b1, 32'hFEDC_BA98});
    strobe(128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", bus.out_valid_o, 1'b1);
      check("bp_data",  bus.out_data_o, 32'h4B5A_6978);
      check("bp_last",  bus.out_last_o, 1'b0);
      step();
    end
    bus.out_ready_i = 1'b1;
    drain("bp_drain");

    // Overflow: 11 strobes into a stalled 8-deep FIFO.
    bus.out_ready_i = 1'b0;
    for (int r = 0; r < 11; r++) begin
      if (r < 8) push_record(mk(r));
      strobe(mk(r));
    end
    check("ovf_level", level, 4'd8);
    check("ovf_drop",  drop_count, 16'd3);
    check("ovf_flag",  overflow, 1'b1);
    bus.out_ready_i = 1'b1;
    drain("ovf_drain");

    // Full FIFO accepting in the same cycle as the head's last-beat handshake.
    bus.out_ready_i = 1'b0;
    for (int r = 0; r < 8; r++) begin
      push_record(mk(16 + r));
      strobe(mk(16 + r));
    end
    check("full_level", level, 4'd8);
    bus.out_ready_i = 1'b1;
    i = 0;
    while (bus.out_last_o !== 1'b1 && i < 20) begin
      step();
      i++;
    end
    check("full_last_seen", bus.out_last_o, 1'b1);
    push_record(mk(40));
    strobe(mk(40));
    check("full_pop_level", level, 4'd8);
    check("full_pop_drop",  drop_count, 16'd3);
    drain("full_drain");

    // Stop instruction: A, B (stop), C.
    stop_en = 1'b1;
    push_record(128'hA3A3_0003_A2A2_0002_A1A1_0001_1234_5678);
    push_record(128'hB3B3_0003_B2B2_0002_B1B1_0001_0700_2E03);
    strobe(128'hA3A3_0003_A2A2_0002_A1A1_0001_1234_5678);
    strobe(128'hB3B3_0003_B2B2_0002_B1B1_0001_0700_2E03);
    strobe(128'hC3C3_0003_C2C2_0002_C1C1_0001_CCCC_CCCC);
    i = 0;
    while (!(bus.out_valid_o === 1'b1 && bus.out_last_o === 1'b1 &&
             bus.out_data_o === 32'hB3B3_0003) && i < 20) begin
      step();
      i++;
    end
    check("stop_b_last", bus.out_data_o, 32'hB3B3_0003);
    check("stop_not_done_yet", done, 1'b0);
    step();
    check("stop_done",  done, 1'b1);
    check("stop_valid", bus.out_valid_o, 1'b0);
    step(); step(); step();
    check("stop_hold_done",  done, 1'b1);
    check("stop_hold_valid", bus.out_valid_o, 1'b0);
    check("stop_drop",  drop_count, 16'd3);
    check("stop_level", level, 4'd0);

    // Reset mid-record after beats 0 and 1, then a fresh record.
    stop_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clear_done", done, 1'b0);
    rec = 128'h5555_0003_5555_0002_5555_0001_5555_0000;
    exp_q.push_back({1'b0, 32'h5555_0000});
    exp_q.push_back({1'b0, 32'h5555_0001});
    strobe(rec);
    step();
    step();
    check("mid_beat2_shown", bus.out_data_o, 32'h5555_0002);
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    bus.out_ready_i = 1'b1;
    rec = 128'h6666_0003_6666_0002_6666_0001_6666_0000;
    push_record(rec);
    strobe(rec);
    check("post_rst_beat0", bus.out_data_o, 32'h6666_0000);
    drain("post_rst_drain");

    step();
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gouram_trace_reader.md
Name: gouram_trace_reader

Overview:
- Consumer end of the Gouram trace interface: accepts the per-instruction trace records the tracer emits and buffers them in a FIFO.
- Serialises each record into 32-bit beats on a valid/ready stream towards a host or trace dump port.
- Counts records lost to back-pressure.
- Implements the "stop on instruction" end-of-run condition in hardware, so system benches and FPGA builds no longer poll the trace output for the terminating instruction word.

Parameters:
- TRACE_WIDTH, 128: width of one trace record; bits [31:0] hold the instruction word.
- DEPTH, 8: FIFO depth in records; power of two, minimum 2.
- CNT_WIDTH, 16: width of the drop counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- trace_valid_i  in  1  one-cycle strobe: trace_data_i holds a new record.
- trace_data_i  in  TRACE_WIDTH  trace record.
- stop_en_i  in  1  enables stop-instruction matching.
- stop_instr_i  in  32  instruction word that terminates the run, e.g. 32'h07002E03.
- out_valid_o  out  1  beat available.
- out_ready_i  in  1  sink accepts beat.
- out_data_o  out  32  beat payload.
- out_last_o  out  1  final beat of the current record.
- level_o  out  $clog2(DEPTH)+1  records currently held, including the one being sent.
- overflow_o  out  1  sticky: at least one record dropped.
- drop_count_o  out  CNT_WIDTH  records dropped, saturating.
- done_o  out  1  stop record fully drained; sticky until reset.

Behaviour:
Beats and handshake
- WORDS = ceil(TRACE_WIDTH/32). Beat k carries record bits [32k+31:32k], zero-padded above TRACE_WIDTH. Beats are sent k=0 first.
- Handshake occurs when out_valid_o && out_ready_i.
- While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o hold stable. out_valid_o never drops without a handshake.

Reset
- rst=1 at a clock edge: FIFO emptied, beat index=0, state IDLE, stopped flag=0.
- All outputs 0 on the following cycle: out_valid_o, out_data_o, out_last_o, level_o, overflow_o, drop_count_o, done_o.
- Reset mid-record discards the partial record; no further beats of it are emitted.

Accept path
- A record is accepted when trace_valid_i=1, stopped=0, and either level<DEPTH or the final beat of the head record handshakes in the same cycle.
- Otherwise a strobe with stopped=0 is dropped: overflow_o<=1 and drop_count_o increments, saturating at all-ones.
- Strobes with stopped=1 are ignored silently; they are not counted.

Stop
- Accepted record with stop_en_i=1 and trace_data_i[31:0]==stop_instr_i sets stopped=1 from the next cycle.
- That record is still buffered and sent.

Latency
- A record accepted at edge N into an empty reader presents beat 0 with out_valid_o=1 in cycle N+1.
- Full throughput with out_ready_i=1: one beat per cycle, with no bubble between records.

FSM (output side)
- IDLE: out_valid_o=0. Goes to SEND when level>0.
- SEND: presents beat idx of the head record; out_last_o=(idx==WORDS-1). On handshake, idx++.
- On the last-beat handshake: pop head, idx=0. Then:
  - if the popped record was the stop record, go to DONE;
  - else if level after pop >0, stay in SEND;
  - else go to IDLE.
- DONE: out_valid_o=0, done_o=1. Exit only by reset.
- Each FIFO entry carries a stop-tag bit.

level_o
- +1 on accept, −1 on last-beat handshake; both in the same cycle gives net 0.
- Never exceeds DEPTH.
- FIFO pointers wrap modulo DEPTH.

Test Plan:
- Single record, TRACE_WIDTH=128, data 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, out_ready_i=1 -> beats 4455_6677, 0011_2233, 89AB_CDEF, 0123_4567 in cycles N+1..N+4; out_last_o only on the 4th beat; level_o returns to 0.
- Back-pressure: out_ready_i=0 for 5 cycles after beat 0 appears -> out_data_o/out_last_o stable, out_valid_o held at 1; resume -> remaining 3 beats follow with no loss.
- Overflow: DEPTH=8, out_ready_i=0, 11 strobes -> level_o=8, drop_count_o=3, overflow_o=1. Drain -> first 8 records in order.
- Full with simultaneous pop: level_o=8 and a strobe in the same cycle as the head's last-beat handshake -> record accepted, drop_count_o unchanged, level_o stays 8.
- Stop: stop_en_i=1, stop_instr_i=32'h07002E03. Records A, B (B[31:0]=07002E03), then C -> A and B emitted, C ignored and drop_count_o unchanged; done_o=1 the cycle after B's last beat handshakes; out_valid_o=0 thereafter.
- Reset mid-record: rst=1 after beat 1 of 4 -> next cycle all outputs 0; a new record afterwards starts at beat 0.
